// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: one-hot Moore FSM. It qualifies button releases, keeps the lap-memory
// pointers, provides a lap-recall browsing mode and forces an exit when a busy handshake
// times out.
module stopwatch_ctrl #(
  parameter int unsigned LAP_AW       = 3,
  parameter int unsigned LAP_WRAP     = 0,
  parameter int unsigned BUSY_TIMEOUT = 1023
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              btn_start_pause,
  input  logic              btn_lap,
  input  logic              btn_reset,
  input  logic              btn_clear,
  input  logic              lcd_busy,
  input  logic              reg_busy,
  output logic [6:0]        state,
  output logic              run_en,
  output logic              time_clear,
  output logic              lap_wr,
  output logic [LAP_AW-1:0] lap_addr,
  output logic              lcd_req,
  output logic              recall,
  output logic [LAP_AW:0]   lap_count,
  output logic              lap_full,
  output logic              timeout_err
);

  typedef enum logic [6:0] {
    StIdle   = 7'b0000001,
    StRun    = 7'b0000010,
    StPause  = 7'b0000100,
    StSave   = 7'b0001000,
    StRecall = 7'b0010000,
    StReset  = 7'b0100000,
    StClear  = 7'b1000000
  } state_e;

  localparam logic [LAP_AW:0] LapFull  = {1'b1, {LAP_AW{1'b0}}};
  localparam logic [15:0]     TmoLimit = 16'(BUSY_TIMEOUT);
  localparam bit              WrapEn   = (LAP_WRAP != 0);

  state_e            state_q, state_d;
  logic [3:0]        prev_q;
  logic [LAP_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LAP_AW-1:0] rd_idx_q, rd_idx_d;
  logic [LAP_AW:0]   lap_count_q, lap_count_d;
  logic [15:0]       tmo_q, tmo_d;
  logic              terr_q, terr_d;
  // High for the first cycle after a state entry, and for the cycle after a recall step.
  logic              first_q, first_d;
  // Recall origin: 0 = IDLE, 1 = PAUSE.
  logic              origin_q, origin_d;

  logic [3:0]        levels, rel;
  logic              ev_clear, ev_reset, ev_sp, ev_lap;
  logic [15:0]       tmo_inc;
  logic              tmo_hit;
  logic              full;
  logic [LAP_AW-1:0] oldest;

  // Release detection: level was high last cycle and is low now. Only the highest event counts.
  assign levels   = {btn_clear, btn_reset, btn_start_pause, btn_lap};
  assign rel      = prev_q & ~levels;
  assign ev_clear = rel[3];
  assign ev_reset = rel[2] & ~rel[3];
  assign ev_sp    = rel[1] & ~|rel[3:2];
  assign ev_lap   = rel[0] & ~|rel[3:1];

  assign full    = (lap_count_q == LapFull);
  assign tmo_inc = tmo_q + 16'd1;
  assign tmo_hit = (tmo_inc >= TmoLimit);
  // In circular mode a full memory starts at the slot that will be overwritten next.
  assign oldest  = (WrapEn && full) ? wr_ptr_q : '0;

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StReset;
      prev_q      <= '0;
      wr_ptr_q    <= '0;
      rd_idx_q    <= '0;
      lap_count_q <= '0;
      tmo_q       <= '0;
      terr_q      <= 1'b0;
      first_q     <= 1'b0;
      origin_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= levels;
      wr_ptr_q    <= wr_ptr_d;
      rd_idx_q    <= rd_idx_d;
      lap_count_q <= lap_count_d;
      tmo_q       <= tmo_d;
      terr_q      <= terr_d;
      first_q     <= first_d;
      origin_q    <= origin_d;
    end
  end

  // Next-state, pointer and timeout logic.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_idx_d    = rd_idx_q;
    lap_count_d = lap_count_q;
    tmo_d       = tmo_q;
    terr_d      = terr_q;
    first_d     = 1'b0;
    origin_d    = origin_q;

    unique case (state_q)
      StIdle: begin
        if (ev_clear) begin
          state_d = StClear;
        end else if (ev_sp) begin
          state_d = StRun;
        end else if (ev_lap && (lap_count_q != '0)) begin
          state_d  = StRecall;
          origin_d = 1'b0;
        end
      end
      StRun: begin
        if (ev_sp) begin
          state_d = StPause;
        end else if (ev_lap && (!full || WrapEn)) begin
          state_d = StSave;
        end
      end
      StSave: begin
        // Buttons are ignored here; the first cycle commits the store, later cycles wait.
        if (first_q) begin
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (!full) lap_count_d = lap_count_q + 1'b1;
        end else if (!lcd_busy) begin
          state_d = StRun;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_hit) begin
            state_d = StRun;
            terr_d  = 1'b1;
          end
        end
      end
      StPause: begin
        if (ev_reset) begin
          state_d = StReset;
        end else if (ev_sp) begin
          state_d = StRun;
        end else if (ev_lap && (lap_count_q != '0)) begin
          state_d  = StRecall;
          origin_d = 1'b1;
        end
      end
      StRecall: begin
        if (ev_clear) begin
          state_d = StClear;
        end else if (ev_sp) begin
          state_d = origin_q ? StPause : StIdle;
        end else if (ev_lap) begin
          first_d = 1'b1;
          if (({1'b0, rd_idx_q} + 1'b1) == lap_count_q) rd_idx_d = '0;
          else                                          rd_idx_d = rd_idx_q + 1'b1;
        end
      end
      StReset: begin
        if (!reg_busy) begin
          state_d = StIdle;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_hit) begin
            state_d = StIdle;
            terr_d  = 1'b1;
          end
        end
      end
      StClear: begin
        if (first_q) begin
          lap_count_d = '0;
          wr_ptr_d    = '0;
          terr_d      = 1'b0;
        end else if (!lcd_busy) begin
          state_d = StReset;
        end else begin
          tmo_d = tmo_inc;
          if (tmo_hit) begin
            state_d = StReset;
            terr_d  = 1'b1;
          end
        end
      end
      default: state_d = StReset;
    endcase

    // Any state change starts a fresh dwell: strobe cycle, zeroed timeout, recall from oldest.
    if (state_d != state_q) begin
      first_d  = 1'b1;
      tmo_d    = '0;
      rd_idx_d = '0;
    end
  end

  // Moore output decodes.
  assign state       = state_q;
  assign run_en      = (state_q == StRun) || (state_q == StSave);
  assign time_clear  = (state_q == StReset);
  assign lap_wr      = (state_q == StSave) && first_q;
  assign lcd_req     = ((state_q == StSave) || (state_q == StClear) || (state_q == StRecall))
                       && first_q;
  assign recall      = (state_q == StRecall);
  assign lap_addr    = recall ? (oldest + rd_idx_q) : wr_ptr_q;
  assign lap_count   = lap_count_q;
  assign lap_full    = full;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Bench for stopwatch_ctrl: a non-wrapping and a wrapping instance share one stimulus and are
// checked every cycle against an arithmetic model, with directed scenarios and random traffic.
module tb_stopwatch_ctrl;
  localparam int AW = 3;
  localparam int D  = 8;
  localparam int TO = 12;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_SAVE = 3;
  localparam int S_RECALL = 4, S_RESET = 5, S_CLEAR = 6;
  localparam int EV_NONE = 0, EV_LAP = 1, EV_SP = 2, EV_RST = 3, EV_CLR = 4;

  logic clock, reset_n;
  logic btn_start_pause, btn_lap, btn_reset, btn_clear, lcd_busy, reg_busy;

  logic [6:0]    o_state     [2];
  logic          o_run_en    [2];
  logic          o_time_clear[2];
  logic          o_lap_wr    [2];
  logic [AW-1:0] o_lap_addr  [2];
  logic          o_lcd_req   [2];
  logic          o_recall    [2];
  logic [AW:0]   o_lap_count [2];
  logic          o_lap_full  [2];
  logic          o_terr      [2];

  int checks, fails;
  bit cmp_en;

  // Model state per instance (index 1 is the wrapping one).
  int       m_st[2], m_age[2], m_wr[2], m_cnt[2], m_rd[2], m_org[2], m_wait[2], m_terr[2];
  int       m_pend[2];
  bit [3:0] m_prev[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    stopwatch_ctrl #(
      .LAP_AW      (AW),
      .LAP_WRAP    (g),
      .BUSY_TIMEOUT(TO)
    ) u_dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .btn_start_pause(btn_start_pause),
      .btn_lap        (btn_lap),
      .btn_reset      (btn_reset),
      .btn_clear      (btn_clear),
      .lcd_busy       (lcd_busy),
      .reg_busy       (reg_busy),
      .state          (o_state[g]),
      .run_en         (o_run_en[g]),
      .time_clear     (o_time_clear[g]),
      .lap_wr         (o_lap_wr[g]),
      .lap_addr       (o_lap_addr[g]),
      .lcd_req        (o_lcd_req[g]),
      .recall         (o_recall[g]),
      .lap_count      (o_lap_count[g]),
      .lap_full       (o_lap_full[g]),
      .timeout_err    (o_terr[g])
    );
  end

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic wait_exit(input int k, input logic busy, output bit done);
    done = 1'b0;
    if (!busy) begin
      done = 1'b1;
    end else begin
      m_wait[k]++;
      if (m_wait[k] >= TO) begin
        done      = 1'b1;
        m_terr[k] = 1;
      end
    end
  endtask

  task automatic model_step(input int k);
    bit [3:0] lv, ev;
    int       top, nxt;
    bit       done;
    if (!reset_n) begin
      m_st[k] = S_RESET; m_age[k] = 0; m_wr[k] = 0; m_cnt[k] = 0; m_rd[k] = 0;
      m_org[k] = S_IDLE; m_wait[k] = 0; m_terr[k] = 0; m_pend[k] = 0; m_prev[k] = '0;
      return;
    end
    lv = {btn_clear, btn_reset, btn_start_pause, btn_lap};
    ev = m_prev[k] & ~lv;
    m_prev[k] = lv;
    top = ev[3] ? EV_CLR : ev[2] ? EV_RST : ev[1] ? EV_SP : ev[0] ? EV_LAP : EV_NONE;
    nxt = m_st[k];
    m_pend[k] = 0;
    case (m_st[k])
      S_IDLE: begin
        if (top == EV_CLR) nxt = S_CLEAR;
        else if (top == EV_SP) nxt = S_RUN;
        else if (top == EV_LAP && m_cnt[k] > 0) begin nxt = S_RECALL; m_org[k] = S_IDLE; end
      end
      S_RUN: begin
        if (top == EV_SP) nxt = S_PAUSE;
        else if (top == EV_LAP && (m_cnt[k] < D || k == 1)) nxt = S_SAVE;
      end
      S_SAVE: begin
        if (m_age[k] == 0) begin
          m_wr[k]  = (m_wr[k] + 1) % D;
          m_cnt[k] = (m_cnt[k] < D) ? m_cnt[k] + 1 : D;
        end else begin
          wait_exit(k, lcd_busy, done);
          if (done) nxt = S_RUN;
        end
      end
      S_PAUSE: begin
        if (top == EV_RST) nxt = S_RESET;
        else if (top == EV_SP) nxt = S_RUN;
        else if (top == EV_LAP && m_cnt[k] > 0) begin nxt = S_RECALL; m_org[k] = S_PAUSE; end
      end
      S_RECALL: begin
        if (top == EV_CLR) nxt = S_CLEAR;
        else if (top == EV_SP) nxt = m_org[k];
        else if (top == EV_LAP) begin
          m_rd[k]   = (m_rd[k] + 1) % m_cnt[k];
          m_pend[k] = 1;
        end
      end
      S_RESET: begin
        wait_exit(k, reg_busy, done);
        if (done) nxt = S_IDLE;
      end
      S_CLEAR: begin
        if (m_age[k] == 0) begin
          m_cnt[k] = 0; m_wr[k] = 0; m_terr[k] = 0;
        end else begin
          wait_exit(k, lcd_busy, done);
          if (done) nxt = S_RESET;
        end
      end
      default: nxt = S_RESET;
    endcase
    if (nxt != m_st[k]) begin
      m_age[k] = 0; m_wait[k] = 0;
      if (nxt == S_RECALL) m_rd[k] = 0;
    end else begin
      m_age[k]++;
    end
    m_st[k] = nxt;
  endtask

  always @(posedge clock) begin
    for (int k = 0; k < 2; k++) model_step(k);
  end

  function automatic logic [20:0] exp_vec(input int k);
    int   st, oldest, addr;
    logic req;
    st     = m_st[k];
    oldest = (k == 1 && m_cnt[k] == D) ? m_wr[k] : 0;
    addr   = (st == S_RECALL) ? (oldest + m_rd[k]) % D : m_wr[k];
    req    = ((st == S_SAVE || st == S_CLEAR || st == S_RECALL) && m_age[k] == 0) ||
             (st == S_RECALL && m_pend[k] != 0);
    return {7'(1 << st), st == S_RUN || st == S_SAVE, st == S_RESET,
            st == S_SAVE && m_age[k] == 0, 3'(addr), req, st == S_RECALL, 4'(m_cnt[k]),
            m_cnt[k] == D, m_terr[k] != 0};
  endfunction

  function automatic logic [20:0] dut_vec(input int k);
    return {o_state[k], o_run_en[k], o_time_clear[k], o_lap_wr[k], o_lap_addr[k],
            o_lcd_req[k], o_recall[k], o_lap_count[k], o_lap_full[k], o_terr[k]};
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
    #1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      0:       btn_lap = v;
      1:       btn_start_pause = v;
      2:       btn_reset = v;
      default: btn_clear = v;
    endcase
  endtask

  task automatic press(input int b);
    set_btn(b, 1'b1);
    cyc();
    set_btn(b, 1'b0);
    cyc();
  endtask

  initial begin
    int stuck_lcd, stuck_reg;
    checks = 0; fails = 0; cmp_en = 1'b0;
    stuck_lcd = 0; stuck_reg = 0;
    btn_start_pause = 0; btn_lap = 0; btn_reset = 0; btn_clear = 0;
    lcd_busy = 0; reg_busy = 0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    cmp_en = 1'b1;
    fork
      forever begin
        @(negedge clock);
        if (cmp_en) begin
          for (int k = 0; k < 2; k++) begin
            checks++;
            if (dut_vec(k) !== exp_vec(k)) begin
              fails++;
              $display("FAIL outputs dut%0d t=%0t got=%h exp=%h", k, $time, dut_vec(k),
                       exp_vec(k));
            end
          end
        end
      end
    join_none

    repeat (3) cyc();
    reset_n = 1'b1;
    chk("reset_state", int'(o_state[0]), 32);
    chk("reset_time_clear", int'(o_time_clear[0]), 1);
    cyc();
    chk("idle_after_reset", int'(o_state[0]), 1);
    press(1);
    chk("run_state", int'(o_state[0]), 2);
    chk("run_en", int'(o_run_en[0]), 1);

    // Three laps with a four-cycle busy response.
    for (int i = 0; i < 3; i++) begin
      press(0);
      chk("save_lap_wr", int'(o_lap_wr[0]), 1);
      chk("save_addr", int'(o_lap_addr[0]), i);
      lcd_busy = 1'b1;
      repeat (4) cyc();
      chk("save_still", int'(o_state[0]), 8);
      lcd_busy = 1'b0;
      cyc();
      chk("save_back_run", int'(o_state[0]), 2);
    end
    chk("three_laps", int'(o_lap_count[0]), 3);

    // Laps 4..9: the ninth exercises full-memory behaviour.
    for (int i = 3; i < 9; i++) begin
      press(0);
      if (i == 8) begin
        chk("nowrap_ignored_state", int'(o_state[0]), 2);
        chk("nowrap_no_wr", int'(o_lap_wr[0]), 0);
        chk("nowrap_full", int'(o_lap_full[0]), 1);
        chk("wrap_wr", int'(o_lap_wr[1]), 1);
        chk("wrap_addr", int'(o_lap_addr[1]), 0);
      end
      cyc();
      cyc();
    end
    chk("wrap_count", int'(o_lap_count[1]), 8);
    chk("nowrap_count", int'(o_lap_count[0]), 8);

    // Recall browsing from PAUSE.
    press(1);
    chk("pause_state", int'(o_state[0]), 4);
    press(0);
    chk("recall_state", int'(o_state[0]), 16);
    chk("recall_flag", int'(o_recall[1]), 1);
    chk("recall_req", int'(o_lcd_req[0]), 1);
    chk("recall_start0", int'(o_lap_addr[0]), 0);
    chk("recall_start1", int'(o_lap_addr[1]), 1);
    for (int i = 1; i <= 8; i++) begin
      press(0);
      chk("recall_step0", int'(o_lap_addr[0]), i % 8);
      chk("recall_step1", int'(o_lap_addr[1]), (1 + i) % 8);
    end
    press(1);
    chk("recall_to_pause", int'(o_state[0]), 4);
    press(0);
    press(3);
    chk("clear_state", int'(o_state[0]), 64);
    chk("clear_req", int'(o_lcd_req[0]), 1);
    cyc();
    chk("clear_count", int'(o_lap_count[1]), 0);
    cyc();
    chk("clear_to_reset", int'(o_state[0]), 32);
    cyc();
    chk("reset_to_idle", int'(o_state[0]), 1);

    // Busy stuck in SAVE.
    press(1);
    press(0);
    lcd_busy = 1'b1;
    repeat (TO) cyc();
    chk("tmo_wait", int'(o_state[0]), 8);
    chk("tmo_not_yet", int'(o_terr[0]), 0);
    cyc();
    chk("tmo_exit", int'(o_state[0]), 2);
    chk("tmo_err", int'(o_terr[0]), 1);
    lcd_busy = 1'b0;
    press(1);
    chk("tmo_sticky", int'(o_terr[0]), 1);
    press(0);
    press(3);
    cyc();
    chk("tmo_cleared", int'(o_terr[0]), 0);
    repeat (2) cyc();
    chk("tmo_idle", int'(o_state[0]), 1);

    // Same-cycle clear and start_pause release in IDLE.
    btn_clear = 1'b1; btn_start_pause = 1'b1;
    cyc();
    btn_clear = 1'b0; btn_start_pause = 1'b0;
    cyc();
    chk("prio_clear", int'(o_state[0]), 64);
    repeat (3) cyc();
    chk("prio_idle", int'(o_state[0]), 1);

    // Asynchronous reset in the middle of SAVE.
    press(1);
    press(0);
    chk("mid_save_wr", int'(o_lap_wr[0]), 1);
    lcd_busy = 1'b1;
    cyc();
    reset_n = 1'b0;
    #1;
    chk("mid_reset_state", int'(o_state[0]), 32);
    chk("mid_reset_wr", int'(o_lap_wr[0]), 0);
    chk("mid_reset_count", int'(o_lap_count[0]), 0);
    repeat (2) cyc();
    reset_n = 1'b1;
    lcd_busy = 1'b0;
    cyc();
    chk("mid_reset_idle", int'(o_state[0]), 1);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      btn_clear       = ($urandom_range(0, 15) == 0);
      btn_reset       = ($urandom_range(0, 7) == 0);
      btn_start_pause = ($urandom_range(0, 3) == 0);
      btn_lap         = ($urandom_range(0, 2) == 0);
      if (stuck_lcd > 0) begin
        lcd_busy = 1'b1;
        stuck_lcd--;
      end else if ($urandom_range(0, 49) == 0) begin
        stuck_lcd = int'($urandom_range(8, 20));
        lcd_busy  = 1'b1;
      end else begin
        lcd_busy = ($urandom_range(0, 1) == 1);
      end
      if (stuck_reg > 0) begin
        reg_busy = 1'b1;
        stuck_reg--;
      end else if ($urandom_range(0, 99) == 0) begin
        stuck_reg = int'($urandom_range(8, 20));
        reg_busy  = 1'b1;
      end else begin
        reg_busy = ($urandom_range(0, 3) == 0);
      end
      reset_n = ($urandom_range(0, 799) != 0);
      cyc();
    end
    reset_n = 1'b1;
    cyc();
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
